// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX integer pipe.
//   XLEN / RW    : default datapath and register-index widths
//   alu_op_e     : 4-bit opcodes understood by the alu
//   fwd_sel_e    : operand source chosen by the bypass network
//   ex_ctl_t     : control fields held in the ID/EX register
//   fwd_hit()    : true when a later stage's result must be bypassed
package dlx_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SGEQ = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    logic [3:0] alu_op;
  } ex_ctl_t;

  // r0 is hard-wired zero, so a write to it never produces a bypass.
  function automatic logic fwd_hit(input logic          we,
                                   input logic [RW-1:0] rd,
                                   input logic [RW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bus between decode / later pipe stages and the ID/EX operand stage.
//   id_*            : decoded instruction presented by the decode stage
//   stall_in/flush  : pipeline control from downstream / branch unit
//   mem_* / wb_*    : EX/MEM and MEM/WB results available for bypass
//   alu_* / ex_*    : EX-stage outputs towards the alu and the MEM stage
//   load_use_stall  : request to hold fetch/decode for one cycle
// Modport slave is the operand stage; master is its environment.
interface ex_operand_stage_if #(
  parameter int XLEN = dlx_pkg::XLEN,
  parameter int RW   = dlx_pkg::RW
);
  logic            id_valid;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic            id_uses_rs2;
  logic [3:0]      id_alu_op;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            stall_in;
  logic            flush_in;
  logic [RW-1:0]   mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RW-1:0]   wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic            ex_valid;
  logic [RW-1:0]   ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_stall;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val, id_imm,
           id_use_imm, id_uses_rs2, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, stall_in, flush_in, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    output alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, load_use_stall
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val, id_imm,
           id_use_imm, id_uses_rs2, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, stall_in, flush_in, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    input  alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/dlx_forward_mux.sv
// One operand bypass: compares the EX source index against the EX/MEM and
// MEM/WB destinations and selects the newest value.
//   rs, reg_val            : EX source index and its registered value
//   mem_rd/mem_we/mem_res  : EX/MEM destination, write enable, result
//   wb_rd/wb_we/wb_res     : MEM/WB destination, write enable, result
//   value                  : forwarded operand
module dlx_forward_mux
  import dlx_pkg::*;
#(
  parameter int XLEN = dlx_pkg::XLEN,
  parameter int RW   = dlx_pkg::RW
) (
  input  logic [RW-1:0]   rs,
  input  logic [XLEN-1:0] reg_val,
  input  logic [RW-1:0]   mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_res,
  input  logic [RW-1:0]   wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_res,
  output logic [XLEN-1:0] value
);

  fwd_sel_e sel;

  // EX/MEM is younger than MEM/WB, so it is checked first.
  always_comb begin
    sel = FWD_REG;
    if (fwd_hit(mem_we, mem_rd, rs))
      sel = FWD_MEM;
    else if (fwd_hit(wb_we, wb_rd, rs))
      sel = FWD_WB;
  end

  always_comb begin
    value = reg_val;
    case (sel)
      FWD_MEM: value = mem_res;
      FWD_WB:  value = wb_res;
      default: value = reg_val;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand forwarding for the DLX integer pipe.
// Captures the decoded instruction, bypasses EX/MEM and MEM/WB results into
// both source operands, detects load-use hazards and drives the alu.
//   clk, reset : single rising-edge clock, synchronous active-high reset
//   bus        : decode inputs, bypass sources, EX outputs (slave side)
// Update priority per edge: reset, stall_in (hold), flush/load-use
// (bubble), normal capture.
module ex_operand_stage
  import dlx_pkg::*;
#(
  parameter int XLEN = dlx_pkg::XLEN,
  parameter int RW   = dlx_pkg::RW
) (
  input  logic                clk,
  input  logic                reset,
  ex_operand_stage_if.slave   bus
);

  ex_ctl_t         ctl_q;
  logic [RW-1:0]   rs1_q;
  logic [RW-1:0]   rs2_q;
  logic [RW-1:0]   rd_q;
  logic [XLEN-1:0] rs1_val_q;
  logic [XLEN-1:0] rs2_val_q;
  logic [XLEN-1:0] imm_q;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            load_use;
  logic            rs1_dep;
  logic            rs2_dep;

  dlx_forward_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_a (
    .rs      (rs1_q),
    .reg_val (rs1_val_q),
    .mem_rd  (bus.mem_rd),
    .mem_we  (bus.mem_reg_write),
    .mem_res (bus.mem_result),
    .wb_rd   (bus.wb_rd),
    .wb_we   (bus.wb_reg_write),
    .wb_res  (bus.wb_result),
    .value   (fwd_a)
  );

  dlx_forward_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_b (
    .rs      (rs2_q),
    .reg_val (rs2_val_q),
    .mem_rd  (bus.mem_rd),
    .mem_we  (bus.mem_reg_write),
    .mem_res (bus.mem_result),
    .wb_rd   (bus.wb_rd),
    .wb_we   (bus.wb_reg_write),
    .wb_res  (bus.wb_result),
    .value   (fwd_b)
  );

  // A load in EX cannot forward its data until MEM, so a dependent
  // instruction in ID must wait one cycle.
  always_comb begin
    rs1_dep  = (bus.id_rs1 == rd_q);
    rs2_dep  = bus.id_uses_rs2 && (bus.id_rs2 == rd_q);
    load_use = ctl_q.valid && ctl_q.mem_read && (rd_q != '0) &&
               bus.id_valid && (rs1_dep || rs2_dep);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
    end else if (bus.stall_in) begin
      // Control holds, but operands absorb any bypass value now, since the
      // producing stage may retire before the stall releases.
      rs1_val_q <= fwd_a;
      rs2_val_q <= fwd_b;
    end else if (bus.flush_in || load_use) begin
      // Bubble clears every field so a dead slot never matches a bypass
      // or load-use compare.
      ctl_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
    end else begin
      ctl_q.valid     <= bus.id_valid;
      ctl_q.reg_write <= bus.id_reg_write;
      ctl_q.mem_read  <= bus.id_mem_read;
      ctl_q.mem_write <= bus.id_mem_write;
      ctl_q.use_imm   <= bus.id_use_imm;
      ctl_q.alu_op    <= bus.id_alu_op;
      rs1_q           <= bus.id_rs1;
      rs2_q           <= bus.id_rs2;
      rd_q            <= bus.id_rd;
      rs1_val_q       <= bus.id_rs1_val;
      rs2_val_q       <= bus.id_rs2_val;
      imm_q           <= bus.id_imm;
    end
  end

  always_comb begin
    bus.alu_a          = fwd_a;
    bus.alu_b          = ctl_q.use_imm ? imm_q : fwd_b;
    bus.alu_op         = ctl_q.alu_op;
    bus.ex_valid       = ctl_q.valid;
    bus.ex_rd          = rd_q;
    bus.ex_reg_write   = ctl_q.valid && ctl_q.reg_write;
    bus.ex_mem_read    = ctl_q.valid && ctl_q.mem_read;
    bus.ex_mem_write   = ctl_q.valid && ctl_q.mem_write;
    bus.ex_store_data  = fwd_b;
    bus.load_use_stall = load_use;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import dlx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_operand_stage_if bus ();
  ex_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rst, stall, flush;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        use_imm, uses_rs2;
    logic [3:0]  op;
    logic        rw, mr, mw;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wres;
    logic        chk;
    logic [31:0] e_a, e_b, e_sd;
    logic [3:0]  e_op;
    logic        e_valid, e_rw, e_mw, e_lus;
  } vec_t;

  // Reference view of the EX slot: the instruction it holds, as decoded.
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } slot_t;

  int n_tests = 0;
  int n_fail  = 0;
  slot_t m;
  vec_t tab[$];

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t id_alu(logic [4:0] rs1, logic [4:0] rs2,
                                  logic [4:0] rd, logic [31:0] v1,
                                  logic [31:0] v2, logic [3:0] op);
    vec_t v;
    v = blank();
    v.id_valid = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.v1 = v1; v.v2 = v2; v.op = op; v.rw = 1'b1; v.uses_rs2 = 1'b1;
    return v;
  endfunction

  function automatic vec_t expect_out(vec_t vi, logic [31:0] a, logic [31:0] b,
                                      logic [31:0] sd, logic [3:0] op,
                                      logic valid, logic rw, logic mw,
                                      logic lus);
    vec_t v;
    v = vi;
    v.chk = 1'b1; v.e_a = a; v.e_b = b; v.e_sd = sd; v.e_op = op;
    v.e_valid = valid; v.e_rw = rw; v.e_mw = mw; v.e_lus = lus;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(logic [4:0] rs, logic [31:0] held,
                                          vec_t v);
    if (v.mrw && v.mrd != 0 && v.mrd == rs) return v.mres;
    if (v.wrw && v.wrd != 0 && v.wrd == rs) return v.wres;
    return held;
  endfunction

  function automatic logic ref_lus(slot_t s, vec_t v);
    return s.valid && s.mr && s.rd != 0 && v.id_valid &&
           (v.rs1 == s.rd || (v.uses_rs2 && v.rs2 == s.rd));
  endfunction

  task automatic drive(input vec_t v);
    reset            = v.rst;
    bus.stall_in     = v.stall;
    bus.flush_in     = v.flush;
    bus.id_valid     = v.id_valid;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_rs1_val   = v.v1;
    bus.id_rs2_val   = v.v2;
    bus.id_imm       = v.imm;
    bus.id_use_imm   = v.use_imm;
    bus.id_uses_rs2  = v.uses_rs2;
    bus.id_alu_op    = v.op;
    bus.id_reg_write = v.rw;
    bus.id_mem_read  = v.mr;
    bus.id_mem_write = v.mw;
    bus.mem_rd       = v.mrd;
    bus.mem_reg_write = v.mrw;
    bus.mem_result   = v.mres;
    bus.wb_rd        = v.wrd;
    bus.wb_reg_write = v.wrw;
    bus.wb_result    = v.wres;
  endtask

  // Advance the reference slot across one clock edge under vector v.
  task automatic model_edge(input vec_t v);
    slot_t nx;
    nx = m;
    if (v.rst) begin
      nx = '{default: '0};
    end else if (v.stall) begin
      nx.v1 = ref_fwd(m.rs1, m.v1, v);
      nx.v2 = ref_fwd(m.rs2, m.v2, v);
    end else if (v.flush || ref_lus(m, v)) begin
      nx = '{default: '0};
    end else begin
      nx.valid = v.id_valid; nx.rs1 = v.rs1; nx.rs2 = v.rs2; nx.rd = v.rd;
      nx.v1 = v.v1; nx.v2 = v.v2; nx.imm = v.imm; nx.use_imm = v.use_imm;
      nx.op = v.op; nx.rw = v.rw; nx.mr = v.mr; nx.mw = v.mw;
    end
    m = nx;
  endtask

  task automatic check_model(input vec_t v);
    logic [31:0] fb;
    fb = ref_fwd(m.rs2, m.v2, v);
    check("rnd ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    check("rnd alu_op", 32'(bus.alu_op), 32'(m.op));
    check("rnd ex_rd", 32'(bus.ex_rd), 32'(m.rd));
    check("rnd reg_write", 32'(bus.ex_reg_write), 32'(m.valid & m.rw));
    check("rnd mem_read", 32'(bus.ex_mem_read), 32'(m.valid & m.mr));
    check("rnd mem_write", 32'(bus.ex_mem_write), 32'(m.valid & m.mw));
    check("rnd load_use", 32'(bus.load_use_stall), 32'(ref_lus(m, v)));
    if (m.valid) begin
      check("rnd alu_a", bus.alu_a, ref_fwd(m.rs1, m.v1, v));
      check("rnd alu_b", bus.alu_b, m.use_imm ? m.imm : fb);
      check("rnd store_data", bus.ex_store_data, fb);
    end
  endtask

  task automatic step_directed(input vec_t v, input int idx);
    string s;
    @(negedge clk);
    drive(v);
    #1;
    if (v.chk) begin
      s = $sformatf("row%0d", idx);
      check({s, " ex_valid"}, 32'(bus.ex_valid), 32'(v.e_valid));
      check({s, " alu_op"}, 32'(bus.alu_op), 32'(v.e_op));
      check({s, " reg_write"}, 32'(bus.ex_reg_write), 32'(v.e_rw));
      check({s, " mem_write"}, 32'(bus.ex_mem_write), 32'(v.e_mw));
      check({s, " load_use"}, 32'(bus.load_use_stall), 32'(v.e_lus));
      if (v.e_valid || v.e_a != 0 || v.e_b != 0) begin
        check({s, " alu_a"}, bus.alu_a, v.e_a);
        check({s, " alu_b"}, bus.alu_b, v.e_b);
        check({s, " store_data"}, bus.ex_store_data, v.e_sd);
      end
    end
    model_edge(v);
    @(posedge clk);
  endtask

  task automatic step_random(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check_model(v);
    model_edge(v);
    @(posedge clk);
  endtask

  initial begin
    vec_t v, x, ld, u, s, st, a2, im;
    m = '{default: '0};
    drive(blank());
    reset = 1'b1;

    // Reset, then a simple ADD r3 = r1 + r2.
    v = blank(); v.rst = 1'b1; tab.push_back(v);
    v = expect_out(id_alu(1, 2, 3, 5, 7, ALU_ADD), 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b0;
    tab.push_back(v);
    tab.push_back(expect_out(blank(), 5, 7, 7, ALU_ADD, 1, 1, 0, 0));

    // Forwarding priority with the same instruction re-issued each cycle.
    x = id_alu(4, 0, 8, 32'h11, 0, ALU_ADD); x.uses_rs2 = 1'b0;
    tab.push_back(expect_out(x, 0, 0, 0, 0, 0, 0, 0, 0));
    v = x; v.mrd = 4; v.mrw = 1; v.mres = 32'h100;
    v.wrd = 4; v.wrw = 1; v.wres = 32'h200;
    tab.push_back(expect_out(v, 32'h100, 0, 0, ALU_ADD, 1, 1, 0, 0));
    v.mrw = 0;
    tab.push_back(expect_out(v, 32'h200, 0, 0, ALU_ADD, 1, 1, 0, 0));
    v = blank(); v.mrd = 0; v.mrw = 1; v.mres = 32'h100;
    tab.push_back(expect_out(v, 32'h11, 0, 0, ALU_ADD, 1, 1, 0, 0));

    // Load-use: load r6 in EX, consumer reads r6.
    ld = id_alu(1, 0, 6, 32'h40, 0, ALU_ADD);
    ld.uses_rs2 = 1'b0; ld.use_imm = 1'b1; ld.imm = 4; ld.mr = 1'b1;
    tab.push_back(expect_out(ld, 0, 0, 0, 0, 0, 0, 0, 0));
    u = id_alu(6, 2, 7, 0, 3, ALU_ADD);
    tab.push_back(expect_out(u, 32'h40, 4, 0, ALU_ADD, 1, 1, 0, 1));
    tab.push_back(expect_out(u, 0, 0, 0, 0, 0, 0, 0, 0));
    v = blank(); v.wrd = 6; v.wrw = 1; v.wres = 32'h77;
    tab.push_back(expect_out(v, 32'h77, 3, 3, ALU_ADD, 1, 1, 0, 0));

    // Stall while WB retires r9: the value must survive the stall.
    s = id_alu(1, 9, 10, 1, 5, ALU_ADD);
    tab.push_back(expect_out(s, 0, 0, 0, 0, 0, 0, 0, 0));
    v = blank(); v.stall = 1; v.wrd = 9; v.wrw = 1; v.wres = 32'hDEAD;
    tab.push_back(expect_out(v, 1, 32'hDEAD, 32'hDEAD, ALU_ADD, 1, 1, 0, 0));
    v.stall = 0; v.wrw = 0;
    tab.push_back(expect_out(v, 1, 32'hDEAD, 32'hDEAD, ALU_ADD, 1, 1, 0, 0));

    // Flush kills the decode slot; flush together with stall holds EX.
    st = id_alu(1, 2, 0, 9, 1, ALU_ADD);
    st.rw = 0; st.mw = 1; st.use_imm = 1; st.imm = 8;
    v = st; v.flush = 1;
    tab.push_back(expect_out(v, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(expect_out(st, 0, 0, 0, 0, 0, 0, 0, 0));
    a2 = id_alu(3, 4, 11, 32'h33, 32'h44, ALU_ADD); a2.flush = 1; a2.stall = 1;
    tab.push_back(expect_out(a2, 9, 8, 1, ALU_ADD, 1, 0, 1, 0));
    tab.push_back(expect_out(blank(), 9, 8, 1, ALU_ADD, 1, 0, 1, 0));

    // Immediate operand versus store data.
    im = id_alu(1, 5, 12, 0, 205, ALU_SUB);
    im.use_imm = 1; im.imm = 32'hFFFF_FFF1; im.uses_rs2 = 0;
    tab.push_back(expect_out(im, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(expect_out(blank(), 0, 32'hFFFF_FFF1, 205, ALU_SUB, 1, 1, 0, 0));

    foreach (tab[i]) step_directed(tab[i], i);

    // Randomized traffic against the reference slot model.
    for (int i = 0; i < 600; i++) begin
      v = blank();
      v.rst      = ($urandom_range(0, 63) == 0);
      v.stall    = ($urandom_range(0, 5) == 0);
      v.flush    = ($urandom_range(0, 7) == 0);
      v.id_valid = ($urandom_range(0, 3) != 0);
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.rd  = 5'($urandom_range(0, 7));
      v.v1 = $urandom; v.v2 = $urandom; v.imm = $urandom;
      v.use_imm = 1'($urandom); v.uses_rs2 = 1'($urandom);
      v.op = 4'($urandom_range(0, 9));
      v.rw = 1'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom);
      v.mrd = 5'($urandom_range(0, 7)); v.mrw = 1'($urandom); v.mres = $urandom;
      v.wrd = 5'($urandom_range(0, 7)); v.wrw = 1'($urandom); v.wres = $urandom;
      step_random(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage of the DLX integer pipe, directly upstream of alu.
- Captures decoded operands and control from the decode stage.
- Resolves RAW hazards by bypassing from EX/MEM and MEM/WB.
- Detects load-use hazards.
- Drives A, B and Op of the alu every cycle.

Parameters:
XLEN, 32, datapath width
RW, 5, register-index width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  decode slot holds a real instruction
id_rs1  in  RW  source register 1 index
id_rs2  in  RW  source register 2 index
id_rd  in  RW  destination index
id_rs1_val  in  XLEN  register-file read 1
id_rs2_val  in  XLEN  register-file read 2
id_imm  in  XLEN  sign/zero-extended immediate
id_use_imm  in  1  B operand = immediate; rs2 not read for ALU
id_uses_rs2  in  1  instruction reads rs2 (ALU B or store data)
id_alu_op  in  4  alu opcode
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
stall_in  in  1  downstream stall; hold EX contents
flush_in  in  1  branch-mispredict kill of the decode instruction
mem_rd  in  RW  EX/MEM destination
mem_reg_write  in  1  EX/MEM write enable
mem_result  in  XLEN  EX/MEM ALU result
wb_rd  in  RW  MEM/WB destination
wb_reg_write  in  1  MEM/WB write enable
wb_result  in  XLEN  MEM/WB writeback value
alu_a  out  XLEN  to alu.A (forwarded)
alu_b  out  XLEN  to alu.B (forwarded rs2, or immediate)
alu_op  out  4  to alu.Op
ex_valid  out  1  EX holds a real instruction
ex_rd  out  RW  EX destination
ex_reg_write  out  1  gated by ex_valid
ex_mem_read  out  1  gated by ex_valid
ex_mem_write  out  1  gated by ex_valid
ex_store_data  out  XLEN  forwarded rs2 for stores
load_use_stall  out  1  to fetch/decode: hold ID, bubble inserted here

Behaviour:
- Reset: all registered fields 0, so ex_valid=0, alu_op=4'b0000, alu_a=alu_b=0, load_use_stall=0.
- Latency: decode inputs captured at edge N appear on outputs after edge N; forwarding is combinational within EX.
- load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Combinational.
- Per-edge update priority:
  1. reset
  2. stall_in: hold all control; operand registers reload with current forwarded values, so WB data retiring during the stall is not lost.
  3. flush_in or load_use_stall: capture bubble; ex_valid=0, all write/mem enables 0, op 0000.
  4. Otherwise capture ID fields; ex_valid=id_valid.
- Forwarding, rs1 then rs2 identically:
  - mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX -> mem_result.
  - Else wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX -> wb_result.
  - Else registered value.
  - MEM has priority over WB; r0 is never forwarded.
- alu_b = imm when ex_use_imm, else forwarded rs2. ex_store_data is always forwarded rs2.
- Enable outputs are ANDed with ex_valid. Operand outputs are not gated.
- A flush arriving together with load_use_stall yields one bubble (same action).
- stall_in together with load_use_stall: stall_in wins; load_use_stall still drives the hold upstream.

Decomposition:
- Package dlx_pkg holds:
  - ALU opcodes: AND=0000, OR=0001, ADD=0010, SUB=0011, XOR=0100, SLL=0101, SRL=0110, SLTU=0111, SLT=1000, SGEQ=1001.
  - XLEN/RW defaults.
  - Forward-select enum: FWD_REG, FWD_MEM, FWD_WB.
- One sub-module, dlx_forward_mux: index compare plus 3:1 select, instantiated twice.

Test Plan:
- Reset pulse -> all outputs 0 and ex_valid=0 after the reset edge; ADD r3=r1+r2 with rs1_val=5, rs2_val=7, op 0010 -> next cycle alu_a=5, alu_b=7, alu_op=0010, ex_valid=1.
- Forwarding priority, EX rs1=4: mem_rd=4, mem_result=0x100 and wb_rd=4, wb_result=0x200 -> alu_a=0x100; drop mem_reg_write -> alu_a=0x200; mem_rd=0 with write set -> no forward.
- Load-use: EX is load to r6, ID reads rs1=6 -> load_use_stall=1; next cycle ex_valid=0, ex_reg_write=0; following cycle the ID instruction is captured.
- Stall with WB retirement: EX rs2=9, wb_rd=9, wb_result=0xDEAD, stall_in=1 for one cycle, then wb_reg_write=0 -> alu_b still 0xDEAD after the stall.
- Flush: flush_in=1 with a valid ADD in ID -> next cycle ex_valid=0 and ex_mem_write=0. Flush and stall_in both set -> contents held.
- Immediate: id_use_imm=1, imm=-15, rs2_val=205, op 0011 -> alu_b=0xFFFFFFF1, ex_store_data=205.
